// File: rtl/booth_mult_sched.sv
// Round-robin scheduler sharing one sequential Booth multiplier among N_REQ requesters,
// with a watchdog that aborts a multiplier that never signals done.
module booth_mult_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 32,
  localparam int unsigned IDW    = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [2*WIDTH-1:0]       rsp_y,
  output logic                     rsp_err,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_done,
  input  logic [2*WIDTH-1:0]       mul_y,
  output logic                     mul_rst,
  output logic [1:0]               state
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       last_grant;
  logic [IDW-1:0]       winner;
  logic [IDW-1:0]       idx;
  logic                 found;
  logic                 accept;
  logic                 done_hit;
  logic                 timeout_hit;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [IDW-1:0]       id_q;
  logic [2*WIDTH-1:0]   y_q;
  logic                 err_q;
  logic [CW-1:0]        cnt_q;

  assign state     = state_q;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign rsp_id    = id_q;
  assign rsp_y     = y_q;
  assign rsp_err   = err_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Round-robin pick, next-state and handshake/pulse outputs
  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    mul_start   = 1'b0;
    rsp_valid   = 1'b0;
    mul_rst     = rst;
    accept      = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    winner      = last_grant;
    idx         = last_grant;
    found       = 1'b0;

    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = IDW'((int'(last_grant) + k) % int'(N_REQ));
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (found && !rst) begin
          req_ready[winner] = 1'b1;
          accept            = 1'b1;
          state_d           = ISSUE;
        end
      end
      ISSUE: begin
        mul_start = !rst;
        state_d   = WAIT;
      end
      WAIT: begin
        // done in the timeout cycle takes priority over the abort
        if (mul_done) begin
          done_hit = 1'b1;
          state_d  = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          mul_rst     = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        rsp_valid = !rst;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) state_d = IDLE;
  end

  // Operand/result capture, grant pointer and watchdog counter
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDW'(N_REQ - 1);
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      y_q        <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (accept) begin
        last_grant <= winner;
        id_q       <= winner;
        a_q        <= req_a[int'(winner)*WIDTH +: WIDTH];
        b_q        <= req_b[int'(winner)*WIDTH +: WIDTH];
      end
      if (state_q == ISSUE)     cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + CW'(1);
      if (done_hit) begin
        y_q   <= mul_y;
        err_q <= 1'b0;
      end else if (timeout_hit) begin
        y_q   <= '0;
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_sched.sv
// Directed bench for booth_mult_sched; the bench plays the multiplier.
module tb_booth_mult_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_y;
  logic        rsp_err;
  logic        mul_start;
  logic [7:0]  mul_a, mul_b;
  logic        mul_done;
  logic [15:0] mul_y;
  logic        mul_rst;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  booth_mult_sched #(.N_REQ(4), .WIDTH(8), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_y(mul_y), .mul_rst(mul_rst),
    .state(state)
  );

  always #5 clk = ~clk;

  // Global time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL global_timeout time limit reached");
    $fatal(1, "time limit");
  end

  // Runs one operation: watches grant, start, mul_rst and response; models done after lat cycles (0 = never)
  task automatic do_op(input int lat, input logic [15:0] y, input bit drop,
                       output int acc_c, output int gid, output int start_c,
                       output int mrst_c, output int rsp_c,
                       output logic [7:0] sa, output logic [7:0] sb);
    acc_c = -1; gid = -1; start_c = -1; mrst_c = -1; rsp_c = -1; sa = '0; sb = '0;
    for (int c = 0; c < 100; c++) begin
      mul_done = (start_c >= 0 && lat > 0 && c == start_c + lat);
      mul_y    = mul_done ? y : 16'h0;
      #1;
      if (acc_c < 0 && (req_ready & req_valid) != 4'h0) begin
        acc_c = c;
        for (int i = 0; i < 4; i++) if (req_ready[i]) gid = i;
      end
      if (start_c < 0 && mul_start) begin
        start_c = c; sa = mul_a; sb = mul_b;
      end
      if (mrst_c < 0 && mul_rst) mrst_c = c;
      if (rsp_valid) begin
        rsp_c = c;
        break;
      end
      @(negedge clk);
      if (drop && acc_c == c) req_valid[gid] = 1'b0;
    end
    mul_done = 1'b0;
    mul_y    = 16'h0;
  endtask

  task automatic accept_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF;
    @(negedge clk);
    #1;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_req_ready got=%h exp=0", req_ready); end
    total++; if (mul_rst !== 1'b1) begin bad++; $display("FAIL reset_mul_rst got=%b exp=1", mul_rst); end
    total++; if (rsp_valid !== 1'b0 || mul_start !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", rsp_valid, mul_start); end
    total++; if (rsp_y !== 16'h0 || rsp_err !== 1'b0 || mul_a !== 8'h0) begin bad++; $display("FAIL reset_data got=%h/%b/%h exp=0", rsp_y, rsp_err, mul_a); end
    rst = 1'b0; req_valid = 4'h0;
    #1;
    total++; if (mul_rst !== 1'b0) begin bad++; $display("FAIL reset_release_mul_rst got=%b exp=0", mul_rst); end
    @(negedge clk);
  endtask

  task automatic test_single();
    int acc_c, gid, sc, mc, rc;
    logic [7:0] sa, sb;
    req_a = 32'h0; req_b = 32'h0;
    req_a[15:8] = 8'hFD; req_b[15:8] = 8'h05;
    req_valid = 4'b0010;
    do_op(10, 16'hFFF1, 1'b1, acc_c, gid, sc, mc, rc, sa, sb);
    total++; if (gid !== 1) begin bad++; $display("FAIL single_grant got=%0d exp=1", gid); end
    total++; if (sc !== acc_c + 1) begin bad++; $display("FAIL single_start_lat got=%0d exp=%0d", sc, acc_c + 1); end
    total++; if (sa !== 8'hFD || sb !== 8'h05) begin bad++; $display("FAIL single_operands got=%h,%h exp=fd,05", sa, sb); end
    total++; if (rc !== sc + 11) begin bad++; $display("FAIL single_rsp_lat got=%0d exp=%0d", rc, sc + 11); end
    total++; if (rsp_id !== 2'd1 || rsp_y !== 16'hFFF1 || rsp_err !== 1'b0) begin bad++; $display("FAIL single_rsp got=%0d/%h/%b exp=1/fff1/0", rsp_id, rsp_y, rsp_err); end
    accept_rsp();
    #1;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL single_back_idle got=%0d exp=0", state); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int acc_c, gid, sc, mc, rc;
    logic [7:0] sa, sb;
    int exp_g [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_a [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
    apply_reset();
    req_a = 32'h40302010; req_b = 32'h04030201;
    req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      do_op(3, 16'h0100 + 16'(n), 1'b0, acc_c, gid, sc, mc, rc, sa, sb);
      total++; if (gid !== exp_g[n] || acc_c !== 0) begin bad++; $display("FAIL rr_grant%0d got=%0d@%0d exp=%0d@0", n, gid, acc_c, exp_g[n]); end
      total++; if (sa !== exp_a[n]) begin bad++; $display("FAIL rr_mul_a%0d got=%h exp=%h", n, sa, exp_a[n]); end
      total++; if (rsp_id !== 2'(exp_g[n]) || rsp_y !== 16'h0100 + 16'(n) || req_ready !== 4'h0) begin
        bad++; $display("FAIL rr_rsp%0d got=%0d/%h/%h exp=%0d/%h/0", n, rsp_id, rsp_y, req_ready, exp_g[n], 16'h0100 + 16'(n));
      end
      accept_rsp();
    end
    req_valid = 4'h0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int acc_c, gid, sc, mc, rc;
    logic [7:0] sa, sb;
    req_valid = 4'b0001;
    do_op(0, 16'hBEEF, 1'b1, acc_c, gid, sc, mc, rc, sa, sb);
    total++; if (mc !== sc + 32) begin bad++; $display("FAIL timeout_mul_rst got=%0d exp=%0d", mc, sc + 32); end
    total++; if (rc !== sc + 33) begin bad++; $display("FAIL timeout_rsp_lat got=%0d exp=%0d", rc, sc + 33); end
    total++; if (rsp_err !== 1'b1 || rsp_y !== 16'h0) begin bad++; $display("FAIL timeout_rsp got=%b/%h exp=1/0000", rsp_err, rsp_y); end
    accept_rsp();
  endtask

  task automatic test_stall();
    int acc_c, gid, sc, mc, rc;
    logic [7:0] sa, sb;
    req_valid = 4'b0100;
    do_op(2, 16'h1234, 1'b1, acc_c, gid, sc, mc, rc, sa, sb);
    @(negedge clk);
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_y !== 16'h1234 || req_ready !== 4'h0) begin
        bad++; $display("FAIL stall_hold%0d got=%b/%0d/%h/%h exp=1/2/1234/0", i, rsp_valid, rsp_id, rsp_y, req_ready);
      end
      @(negedge clk);
    end
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    total++; if (state !== 2'd0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL stall_idle got=%0d/%b exp=0/0", state, rsp_valid); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    req_valid = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (mul_start) begin seen = 1'b1; break; end
      @(negedge clk);
      req_valid = 4'h0;
    end
    total++; if (!seen) begin bad++; $display("FAIL rstmid_start got=0 exp=1"); end
    repeat (3) @(negedge clk);
    #1;
    total++; if (state !== 2'd2) begin bad++; $display("FAIL rstmid_in_wait got=%0d exp=2", state); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (state !== 2'd0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%0d/%b exp=0/0", state, rsp_valid); end
    req_valid = 4'hF;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rstmid_next_grant got=%b exp=0001", req_ready); end
    req_valid = 4'h0;
    @(negedge clk);
  endtask

  task automatic test_done_at_timeout();
    int acc_c, gid, sc, mc, rc;
    logic [7:0] sa, sb;
    req_a = 32'h0; req_b = 32'h0;
    req_a[7:0] = 8'h7F; req_b[7:0] = 8'h80;
    req_valid = 4'b0001;
    do_op(32, 16'hC080, 1'b1, acc_c, gid, sc, mc, rc, sa, sb);
    total++; if (sa !== 8'h7F || sb !== 8'h80) begin bad++; $display("FAIL race_operands got=%h,%h exp=7f,80", sa, sb); end
    total++; if (mc !== -1) begin bad++; $display("FAIL race_no_mul_rst got=%0d exp=-1", mc); end
    total++; if (rc !== sc + 33) begin bad++; $display("FAIL race_rsp_lat got=%0d exp=%0d", rc, sc + 33); end
    total++; if (rsp_err !== 1'b0 || rsp_y !== 16'hC080) begin bad++; $display("FAIL race_rsp got=%b/%h exp=0/c080", rsp_err, rsp_y); end
    accept_rsp();
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'h0; req_a = 32'h0; req_b = 32'h0;
    rsp_ready = 1'b0; mul_done = 1'b0; mul_y = 16'h0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_stall();
    test_reset_mid();
    test_done_at_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
